// File: rtl/decode_regfile_scoreboard_if.sv
// Decode/writeback bundle: fetch instruction, writeback write port, redirect,
// and the combinational operand/stall/issue results returned to decode.
interface decode_regfile_scoreboard_if #(
    parameter int unsigned XLEN = 64
);
    logic            DE_V;
    logic [31:0]     DE_IR;
    logic            DE_HOLD;
    logic            OUT_FE_REG_WEN;
    logic [4:0]      OUT_DE_DR;
    logic [XLEN-1:0] OUT_DE_Data;
    logic            OUT_FE_PC_MUX;
    logic [XLEN-1:0] DE_RS1_DATA;
    logic [XLEN-1:0] DE_RS2_DATA;
    logic            STALL;
    logic            DE_ISSUE;

    modport master (
        output DE_V, DE_IR, DE_HOLD, OUT_FE_REG_WEN, OUT_DE_DR, OUT_DE_Data, OUT_FE_PC_MUX,
        input  DE_RS1_DATA, DE_RS2_DATA, STALL, DE_ISSUE
    );

    modport slave (
        input  DE_V, DE_IR, DE_HOLD, OUT_FE_REG_WEN, OUT_DE_DR, OUT_DE_Data, OUT_FE_PC_MUX,
        output DE_RS1_DATA, DE_RS2_DATA, STALL, DE_ISSUE
    );
endinterface

// File: rtl/decode_regfile_scoreboard.sv
// Decode-side register file with writeback bypass, per-register pending-write
// counters and RAW/WAW stall generation.
module decode_regfile_scoreboard #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned NREG  = 32,
    parameter int unsigned CNT_W = 2
) (
    input logic                    CLK,
    input logic                    RESET,
    decode_regfile_scoreboard_if.slave bus
);
    localparam int unsigned REG_W = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;

    logic [XLEN-1:0]  regs     [NREG];
    logic [CNT_W-1:0] cnt      [NREG];
    logic [CNT_W-1:0] cnt_next [NREG];

    logic [REG_W-1:0] rs1, rs2, rd;
    logic [6:0]       opcode;
    logic             use_rs1, use_rs2, use_rd;
    logic             wb_hit, raw, waw, stall, issue;
    logic [NREG-1:0]  inc_vec, dec_vec;

    // funct3/funct7 do not affect operand usage
    wire unused_funct = &{1'b0, bus.DE_IR[31:25], bus.DE_IR[14:12]};

    assign rs1    = bus.DE_IR[19:15];
    assign rs2    = bus.DE_IR[24:20];
    assign rd     = bus.DE_IR[11:7];
    assign opcode = bus.DE_IR[6:0];
    assign wb_hit = bus.OUT_FE_REG_WEN && (bus.OUT_DE_DR != '0);

    // Operand-usage decode from the major opcode
    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        use_rd  = 1'b0;
        case (opcode)
            OPC_OP, OPC_OP_32: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                use_rd  = 1'b1;
            end
            OPC_BRANCH, OPC_STORE: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_OP_IMM, OPC_OP_IMM_32, OPC_LOAD, OPC_JALR: begin
                use_rs1 = 1'b1;
                use_rd  = 1'b1;
            end
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                use_rd  = 1'b1;
            end
            default: ;
        endcase
    end

    // Read port: x0 is zero, a same-cycle writeback wins over the array
    function automatic logic [XLEN-1:0] read_reg(input logic [REG_W-1:0] rs);
        if (rs == '0)
            return '0;
        else if (bus.OUT_FE_REG_WEN && bus.OUT_DE_DR == rs)
            return bus.OUT_DE_Data;
        else
            return regs[rs];
    endfunction

    // A register stops being busy in the cycle its last pending write lands
    function automatic logic busy(input logic [REG_W-1:0] r);
        return (cnt[r] != '0) &&
               !(bus.OUT_FE_REG_WEN && bus.OUT_DE_DR == r && cnt[r] == CNT_W'(1));
    endfunction

    // Hazard detection and issue decision
    always_comb begin
        raw   = (use_rs1 && rs1 != '0 && busy(rs1)) ||
                (use_rs2 && rs2 != '0 && busy(rs2));
        // A writeback to rd in this cycle frees a slot, so a full counter does not block
        waw   = use_rd && rd != '0 && cnt[rd] == CNT_MAX &&
                !(wb_hit && bus.OUT_DE_DR == rd);
        stall = bus.DE_V && (raw || waw);
        issue = bus.DE_V && !stall && !bus.DE_HOLD && !bus.OUT_FE_PC_MUX;
    end

    assign bus.DE_RS1_DATA = read_reg(rs1);
    assign bus.DE_RS2_DATA = read_reg(rs2);
    assign bus.STALL       = stall;
    assign bus.DE_ISSUE    = issue;

    // Next pending-write counts: issue increments, writeback decrements, redirect clears
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            cnt_next[r] = cnt[r];
            if (r != 0) begin
                inc_vec[r] = issue && use_rd && (rd == REG_W'(r));
                dec_vec[r] = wb_hit && (bus.OUT_DE_DR == REG_W'(r));
            end
            if (bus.OUT_FE_PC_MUX)
                cnt_next[r] = '0;
            else if (inc_vec[r] && !dec_vec[r])
                cnt_next[r] = cnt[r] + CNT_W'(1);
            else if (dec_vec[r] && !inc_vec[r] && cnt[r] != '0)
                cnt_next[r] = cnt[r] - CNT_W'(1);
        end
    end

    // Counter state
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int unsigned r = 0; r < NREG; r++)
                cnt[r] <= '0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++)
                cnt[r] <= cnt_next[r];
        end
    end

    // Register array; writes to x0 are dropped, redirect does not block writeback
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int unsigned r = 0; r < NREG; r++)
                regs[r] <= '0;
        end else if (wb_hit) begin
            regs[bus.OUT_DE_DR] <= bus.OUT_DE_Data;
        end
    end
endmodule

// File: tb/tb_decode_regfile_scoreboard.sv
// Directed bench for decode_regfile_scoreboard: bypass, scoreboard stalls,
// redirect flush, counter saturation, hold and asynchronous reset.
module tb_decode_regfile_scoreboard;
    localparam int unsigned XLEN = 64;

    logic CLK = 1'b0;
    logic RESET;
    int   checks   = 0;
    int   failures = 0;

    always #5 CLK = ~CLK;

    decode_regfile_scoreboard_if #(.XLEN(XLEN)) bus ();

    decode_regfile_scoreboard #(.XLEN(XLEN), .NREG(32), .CNT_W(2)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_si(input string tag, input logic exp_stall, input logic exp_issue);
        check_eq({tag, ".stall"}, 64'(bus.STALL), 64'(exp_stall));
        check_eq({tag, ".issue"}, 64'(bus.DE_ISSUE), 64'(exp_issue));
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ir, input logic hold,
                         input logic wen, input logic [4:0] dr, input logic [63:0] data,
                         input logic pcmux);
        bus.DE_V           = v;
        bus.DE_IR          = ir;
        bus.DE_HOLD        = hold;
        bus.OUT_FE_REG_WEN = wen;
        bus.OUT_DE_DR      = dr;
        bus.OUT_DE_Data    = data;
        bus.OUT_FE_PC_MUX  = pcmux;
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] itype(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [11:0] imm);
        return {imm, rs1, 3'b000, rd, 7'b0010011};
    endfunction

    initial begin
        RESET = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0);
        #12;
        check_si("reset_idle", 1'b0, 1'b0);
        check_eq("reset_rs1", bus.DE_RS1_DATA, 64'h0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;

        // 1: add x3,x1,x2 after reset
        drive(1'b1, rtype(5'd3, 5'd1, 5'd2), 1'b0, 1'b0, 5'd0, 64'h0, 1'b0);
        check_si("t1_add", 1'b0, 1'b1);
        check_eq("t1_rs1", bus.DE_RS1_DATA, 64'h0);
        check_eq("t1_rs2", bus.DE_RS2_DATA, 64'h0);
        tick();

        // 2: RAW on x5, released by writeback in the same cycle via bypass
        drive(1'b1, 32'h0020_8293, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0);
        check_si("t2_addi", 1'b0, 1'b1);
        tick();
        drive(1'b1, rtype(5'd6, 5'd5, 5'd5), 1'b0, 1'b0, 5'd0, 64'h0, 1'b0);
        check_si("t2_raw", 1'b1, 1'b0);
        tick();
        check_si("t2_raw_hold", 1'b1, 1'b0);
        drive(1'b1, rtype(5'd6, 5'd5, 5'd5), 1'b0, 1'b1, 5'd5, 64'h1234, 1'b0);
        check_si("t2_wb", 1'b0, 1'b1);
        check_eq("t2_byp_rs1", bus.DE_RS1_DATA, 64'h1234);
        check_eq("t2_byp_rs2", bus.DE_RS2_DATA, 64'h1234);
        tick();
        drive(1'b1, rtype(5'd11, 5'd5, 5'd5), 1'b0, 1'b0, 5'd0, 64'h0, 1'b0);
        check_si("t2_arr", 1'b0, 1'b1);
        check_eq("t2_arr_rs1", bus.DE_RS1_DATA, 64'h1234);
        tick();

        // 3: writes to x0 are dropped and x0 never stalls
        drive(1'b1, rtype(5'd12, 5'd0, 5'd0), 1'b0, 1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        check_eq("t3_x0_byp", bus.DE_RS1_DATA, 64'h0);
        check_si("t3_x0_wb", 1'b0, 1'b1);
        tick();
        drive(1'b1, rtype(5'd13, 5'd0, 5'd0), 1'b0, 1'b0, 5'd0, 64'h0, 1'b0);
        check_eq("t3_x0_arr", bus.DE_RS2_DATA, 64'h0);
        check_si("t3_x0", 1'b0, 1'b1);
        tick();

        // 4: redirect clears the scoreboard but keeps the concurrent writeback
        drive(1'b1, itype(5'd7, 5'd0, 12'd1), 1'b0, 1'b0, 5'd0, 64'h0, 1'b0);
        check_si("t4_w7", 1'b0, 1'b1);
        tick();
        drive(1'b1, rtype(5'd14, 5'd7, 5'd0), 1'b0, 1'b1, 5'd9, 64'h55, 1'b1);
        check_si("t4_redir_raw", 1'b1, 1'b0);
        drive(1'b1, itype(5'd15, 5'd0, 12'd0), 1'b0, 1'b1, 5'd9, 64'h55, 1'b1);
        check_si("t4_redir_noiss", 1'b0, 1'b0);
        tick();
        drive(1'b1, rtype(5'd14, 5'd7, 5'd9), 1'b0, 1'b0, 5'd0, 64'h0, 1'b0);
        check_si("t4_after", 1'b0, 1'b1);
        check_eq("t4_x9", bus.DE_RS2_DATA, 64'h55);
        check_eq("t4_x7", bus.DE_RS1_DATA, 64'h0);
        tick();

        // 5: three writers of x8 saturate; one writeback frees a slot that cycle
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, itype(5'd8, 5'd0, 12'd1), 1'b0, 1'b0, 5'd0, 64'h0, 1'b0);
            check_si($sformatf("t5_w8_%0d", i), 1'b0, 1'b1);
            tick();
        end
        drive(1'b1, itype(5'd8, 5'd0, 12'd1), 1'b0, 1'b0, 5'd0, 64'h0, 1'b0);
        check_si("t5_waw", 1'b1, 1'b0);
        tick();
        drive(1'b1, itype(5'd8, 5'd0, 12'd1), 1'b0, 1'b1, 5'd8, 64'h88, 1'b0);
        check_si("t5_wb_free", 1'b0, 1'b1);
        tick();
        drive(1'b1, itype(5'd8, 5'd0, 12'd1), 1'b0, 1'b0, 5'd0, 64'h0, 1'b0);
        check_si("t5_still_full", 1'b1, 1'b0);
        tick();
        drive(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 64'h0, 1'b1);
        tick();

        // 6: issue+writeback on the same reg keeps the count; hold does not count
        drive(1'b1, itype(5'd10, 5'd0, 12'd1), 1'b0, 1'b0, 5'd0, 64'h0, 1'b0);
        check_si("t6_w10", 1'b0, 1'b1);
        tick();
        drive(1'b1, itype(5'd10, 5'd0, 12'd1), 1'b0, 1'b1, 5'd10, 64'hA, 1'b0);
        check_si("t6_w10_wb", 1'b0, 1'b1);
        tick();
        drive(1'b1, rtype(5'd16, 5'd10, 5'd0), 1'b0, 1'b0, 5'd0, 64'h0, 1'b0);
        check_si("t6_cnt_kept", 1'b1, 1'b0);
        check_eq("t6_x10_arr", bus.DE_RS1_DATA, 64'hA);
        tick();
        drive(1'b1, itype(5'd10, 5'd0, 12'd1), 1'b1, 1'b0, 5'd0, 64'h0, 1'b0);
        check_si("t6_hold", 1'b0, 1'b0);
        tick();
        drive(1'b1, rtype(5'd16, 5'd10, 5'd0), 1'b0, 1'b1, 5'd10, 64'hB, 1'b0);
        check_si("t6_hold_nocnt", 1'b0, 1'b1);
        check_eq("t6_x10_byp", bus.DE_RS1_DATA, 64'hB);
        tick();

        // STALL ignores DE_HOLD; unknown opcodes use nothing
        drive(1'b1, rtype(5'd18, 5'd16, 5'd5), 1'b1, 1'b0, 5'd0, 64'h0, 1'b0);
        check_si("hold_raw", 1'b1, 1'b0);
        check_eq("x5_arr", bus.DE_RS2_DATA, 64'h1234);
        drive(1'b1, {12'd0, 5'd16, 3'b000, 5'd0, 7'b0001111}, 1'b0, 1'b0, 5'd0, 64'h0, 1'b0);
        check_si("fence_nouse", 1'b0, 1'b1);
        tick();

        // Asynchronous reset mid-cycle clears counters and the array at once
        drive(1'b1, rtype(5'd18, 5'd16, 5'd5), 1'b0, 1'b0, 5'd0, 64'h0, 1'b0);
        check_si("pre_rst_raw", 1'b1, 1'b0);
        RESET = 1'b1;
        #1;
        check_eq("rst_async_stall", 64'(bus.STALL), 64'h0);
        check_eq("rst_async_x5", bus.DE_RS2_DATA, 64'h0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        #1;
        check_si("post_rst", 1'b0, 1'b1);
        check_eq("post_rst_x5", bus.DE_RS2_DATA, 64'h0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
